// File: rtl/bus_ctrl_pkg.sv
// Shared definitions for the register-to-register bus transfer controller:
// FSM state encoding, default sizes and the index-width helper.
package bus_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      LOAD  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int NREG_DEF = 4;
   localparam int NREQ_DEF = 2;

   // Index width for n items; never below one bit so single-entry vectors stay legal.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bus_xfer_ctrl_if.sv
// Request/bus-control bundle between requesters and the transfer controller.
interface bus_xfer_ctrl_if
   import bus_ctrl_pkg::*;
#(
   parameter int NREG = NREG_DEF,
   parameter int NREQ = NREQ_DEF
);
   localparam int SW = idx_w(NREG);

   logic [NREQ-1:0]    req;
   logic [NREQ*SW-1:0] src;
   logic [NREQ*SW-1:0] dst;
   logic [NREG-1:0]    oe;
   logic [NREG-1:0]    load;
   logic [NREQ-1:0]    done;
   logic               err;
   logic               busy;

   modport master (
      input  req, src, dst,
      output oe, load, done, err, busy
   );

   modport slave (
      output req, src, dst,
      input  oe, load, done, err, busy
   );

endinterface

// File: rtl/rr_arbiter.sv
// Request arbiter for the transfer controller. BUSCTRL_RR_EN selects round-robin
// (pointer after last winner); otherwise fixed priority with lowest index winning.
module rr_arbiter
   import bus_ctrl_pkg::*;
#(
   parameter int NREQ = NREQ_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NREQ-1:0] req,
   input  logic            accept,
   output logic [NREQ-1:0] grant
);

   logic found;

`ifdef BUSCTRL_RR_EN
   localparam int PW = idx_w(NREQ);

   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_nxt;

   // Two passes: requesters at or above the pointer first, then wrap to index 0.
   always_comb begin
      grant   = '0;
      ptr_nxt = ptr;
      found   = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!found && req[i] && (i >= 32'(ptr))) begin
            grant[i] = 1'b1;
            found    = 1'b1;
            ptr_nxt  = (i == NREQ - 1) ? '0 : PW'(i + 1);
         end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!found && req[i]) begin
            grant[i] = 1'b1;
            found    = 1'b1;
            ptr_nxt  = (i == NREQ - 1) ? '0 : PW'(i + 1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      ptr <= '0;
      else if (accept) ptr <= ptr_nxt;
   end
`else
   logic unused_ok;
   assign unused_ok = ^{clk, reset, accept};

   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!found && req[i]) begin
            grant[i] = 1'b1;
            found    = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Shared-bus transfer controller: arbitrates requesters, drives oe/load to move
// one register onto another. Arbitration mode set by BUSCTRL_RR_EN (see rr_arbiter).
module bus_xfer_ctrl
   import bus_ctrl_pkg::*;
#(
   parameter int NREG = NREG_DEF,
   parameter int NREQ = NREQ_DEF
) (
   input  logic              clk,
   input  logic              reset,
   bus_xfer_ctrl_if.master   bus
);

   localparam int SW = idx_w(NREG);

   state_t          state, state_nxt;
   logic [SW-1:0]   src_q, dst_q, src_nxt, dst_nxt, sel_src, sel_dst;
   logic [NREQ-1:0] win_q, win_nxt, grant;
   logic [NREG-1:0] oe_q, oe_nxt, load_q, load_nxt;
   logic [NREQ-1:0] done_q, done_nxt;
   logic            err_q, err_nxt;
   logic            accept, reject;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk    (clk),
      .reset  (reset),
      .req    (bus.req),
      .accept (accept),
      .grant  (grant)
   );

   always_comb begin
      sel_src = '0;
      sel_dst = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_src = bus.src[i*SW +: SW];
            sel_dst = bus.dst[i*SW +: SW];
         end
      end
      reject = (sel_src == sel_dst) || (32'(sel_src) >= NREG) || (32'(sel_dst) >= NREG);
   end

   always_comb begin
      state_nxt = state;
      src_nxt   = src_q;
      dst_nxt   = dst_q;
      win_nxt   = win_q;
      err_nxt   = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (|bus.req) begin
               accept  = 1'b1;
               src_nxt = sel_src;
               dst_nxt = sel_dst;
               win_nxt = grant;
               if (reject) begin
                  state_nxt = DONE;
                  err_nxt   = 1'b1;
               end else begin
                  state_nxt = DRIVE;
               end
            end
         end
         DRIVE:   state_nxt = LOAD;
         LOAD:    state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they come straight off flops.
   always_comb begin
      oe_nxt   = '0;
      load_nxt = '0;
      done_nxt = '0;
      if (state_nxt == DRIVE || state_nxt == LOAD) oe_nxt[src_nxt]   = 1'b1;
      if (state_nxt == LOAD)                       load_nxt[dst_nxt] = 1'b1;
      if (state_nxt == DONE)                       done_nxt          = win_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         src_q  <= '0;
         dst_q  <= '0;
         win_q  <= '0;
         oe_q   <= '0;
         load_q <= '0;
         done_q <= '0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_nxt;
         src_q  <= src_nxt;
         dst_q  <= dst_nxt;
         win_q  <= win_nxt;
         oe_q   <= oe_nxt;
         load_q <= load_nxt;
         done_q <= done_nxt;
         err_q  <= err_nxt;
      end
   end

   assign bus.oe   = oe_q;
   assign bus.load = load_q;
   assign bus.done = done_q;
   assign bus.err  = err_q;
   assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: eight registers on one shared bus, directed cases
// plus randomized transfers against a transaction-level reference model.
module tb_bus_xfer_ctrl;

   localparam int NREG = 8;
   localparam int NREQ = 2;
   localparam int SW   = 3;

   logic clk;
   logic reset;

   bus_xfer_ctrl_if #(.NREG(NREG), .NREQ(NREQ)) bif ();

   bus_xfer_ctrl #(.NREG(NREG), .NREQ(NREQ)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   logic [7:0] regs  [NREG];
   logic [7:0] mregs [NREG];
   logic [7:0] bus_v;
   logic       pl_en;
   logic [2:0] pl_idx;
   logic [7:0] pl_val;

   int n_err   = 0;
   int n_chk   = 0;
   int rr_next = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Shared bus: whichever register has oe drives it.
   always_comb begin
      bus_v = '0;
      for (int i = 0; i < NREG; i++)
         if (bif.oe[i]) bus_v = bus_v | regs[i];
   end

   always @(posedge clk) begin
      if (pl_en) regs[pl_idx] <= pl_val;
      for (int i = 0; i < NREG; i++)
         if (bif.load[i]) regs[i] <= bus_v;
   end

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Bus exclusivity every cycle; a load must always see exactly one driver.
   always @(negedge clk) begin
      if (reset) begin
         chk_eq("oe_onehot0", 32'($onehot0(bif.oe)), 32'd1);
         chk_eq("load_onehot0", 32'($onehot0(bif.load)), 32'd1);
         if (|bif.load) chk_eq("load_bus_driven", 32'($onehot(bif.oe)), 32'd1);
      end
   end

   function automatic int pick(input logic [NREQ-1:0] r);
`ifdef BUSCTRL_RR_EN
      for (int k = 0; k < NREQ; k++)
         if (r[(rr_next + k) % NREQ]) return (rr_next + k) % NREQ;
`else
      for (int i = 0; i < NREQ; i++)
         if (r[i]) return i;
`endif
      return 0;
   endfunction

   // Call at the negedge of an idle cycle; returns with the DUT idle again.
   task automatic xfer(input logic [NREQ-1:0] r, input logic [NREQ*SW-1:0] s,
                       input logic [NREQ*SW-1:0] d, input bit drop, output int w_obs);
      int              w, n;
      logic [SW-1:0]   sw, dw;
      bit              v;
      logic [NREG-1:0] e_oe, e_ld;
      logic [NREQ-1:0] e_dn;
      bif.req = r;
      bif.src = s;
      bif.dst = d;
      w  = pick(r);
      sw = s[w*SW +: SW];
      dw = d[w*SW +: SW];
      v  = (sw != dw);
      n  = v ? 3 : 1;
      rr_next = (w + 1) % NREQ;
      w_obs = -1;
      for (int c = 1; c <= n; c++) begin
         @(posedge clk); #1;
         e_oe = '0;
         e_ld = '0;
         e_dn = '0;
         if (v && c <= 2) e_oe[sw] = 1'b1;
         if (v && c == 2) e_ld[dw] = 1'b1;
         if (c == n)      e_dn[w]  = 1'b1;
         chk_eq("oe", 32'(bif.oe), 32'(e_oe));
         chk_eq("load", 32'(bif.load), 32'(e_ld));
         chk_eq("done", 32'(bif.done), 32'(e_dn));
         chk_eq("err", 32'(bif.err), 32'(!v && c == n));
         chk_eq("busy", 32'(bif.busy), 32'd1);
         for (int i = 0; i < NREQ; i++)
            if (bif.done[i]) w_obs = i;
         if (c == 1 && drop) bif.req = '0;
      end
      if (v) mregs[dw] = mregs[sw];
      @(posedge clk); #1;
      chk_eq("idle_busy", 32'(bif.busy), 32'd0);
      chk_eq("idle_oe", 32'(bif.oe), 32'd0);
      chk_eq("idle_done", 32'(bif.done), 32'd0);
      chk_eq("reg_dst", 32'(regs[dw]), 32'(mregs[dw]));
      @(negedge clk);
   endtask

   initial begin
      int                 w;
      logic [NREQ-1:0]    r;
      logic [NREQ*SW-1:0] s, d;
      logic [SW-1:0]      t;

      reset   = 1'b0;
      pl_en   = 1'b0;
      pl_idx  = '0;
      pl_val  = '0;
      bif.req = '0;
      bif.src = '0;
      bif.dst = '0;
      #2;
      chk_eq("rst_oe", 32'(bif.oe), 32'd0);
      chk_eq("rst_load", 32'(bif.load), 32'd0);
      chk_eq("rst_done", 32'(bif.done), 32'd0);
      chk_eq("rst_err", 32'(bif.err), 32'd0);
      chk_eq("rst_busy", 32'(bif.busy), 32'd0);

      for (int i = 0; i < NREG; i++) begin
         @(negedge clk);
         pl_en    = 1'b1;
         pl_idx   = 3'(i);
         pl_val   = (i == 0) ? 8'hA5 : 8'($urandom);
         mregs[i] = pl_val;
      end
      @(negedge clk);
      pl_en = 1'b0;
      reset = 1'b1;

      // Single transfer reg0 -> reg2 by requester 0.
      xfer(2'b01, {3'd0, 3'd0}, {3'd0, 3'd2}, 1'b0, w);
      chk_eq("single_winner", 32'(w), 32'd0);
      chk_eq("single_reg2", 32'(regs[2]), 32'hA5);

      // Rejected request: requester 1 with src == dst == 1.
      xfer(2'b10, {3'd1, 3'd0}, {3'd1, 3'd0}, 1'b0, w);
      chk_eq("invalid_winner", 32'(w), 32'd1);

      // Contention: both requesters held high.
      for (int k = 0; k < 4; k++) begin
         xfer(2'b11, {3'd4, 3'd1}, {3'd6, 3'd3}, 1'b0, w);
`ifdef BUSCTRL_RR_EN
         chk_eq("arb_seq", 32'(w), 32'(k % 2));
`else
         chk_eq("arb_seq", 32'(w), 32'd0);
`endif
      end

      // Reset asserted during LOAD: outputs drop without a clock edge.
      bif.req = 2'b01;
      bif.src = {3'd0, 3'd3};
      bif.dst = {3'd0, 3'd5};
      @(posedge clk); #1;
      chk_eq("rl_drive_oe", 32'(bif.oe), 32'h08);
      @(posedge clk); #1;
      chk_eq("rl_load", 32'(bif.load), 32'h20);
      #2;
      reset   = 1'b0;
      bif.req = '0;
      #1;
      chk_eq("rl_async_oe", 32'(bif.oe), 32'd0);
      chk_eq("rl_async_load", 32'(bif.load), 32'd0);
      chk_eq("rl_async_busy", 32'(bif.busy), 32'd0);
      @(posedge clk); #1;
      chk_eq("rl_no_done", 32'(bif.done), 32'd0);
      chk_eq("rl_reg5_kept", 32'(regs[5]), 32'(mregs[5]));
      @(negedge clk);
      reset   = 1'b1;
      rr_next = 0;
      xfer(2'b01, {3'd0, 3'd3}, {3'd0, 3'd5}, 1'b0, w);
      chk_eq("rl_after_winner", 32'(w), 32'd0);

      // Randomized transfers, some with req dropped right after the grant.
      for (int it = 0; it < 1000; it++) begin
         r = NREQ'($urandom_range(1, 3));
         for (int q = 0; q < NREQ; q++) begin
            t = SW'($urandom_range(0, NREG - 1));
            s[q*SW +: SW] = t;
            d[q*SW +: SW] = ($urandom_range(0, 4) == 0) ? t : SW'($urandom_range(0, NREG - 1));
         end
         xfer(r, s, d, 1'($urandom_range(0, 1)), w);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/bus_xfer_ctrl.md
BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

Interface
REQ-001 Parameter NREG, default 4: number of regN registers sharing one tri-state bus, 2..16.
REQ-002 Parameter NREQ, default 2: number of requesters, 1..8.
REQ-003 Derived constant SW = $clog2(NREG): width of each register index.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req  in  NREQ  per-requester transfer request, level, held until done.
REQ-007 src  in  NREQ*SW  packed source register index per requester.
REQ-008 dst  in  NREQ*SW  packed destination register index per requester.
REQ-009 oe  out  NREG  per-register output enable; at most one bit high.
REQ-010 load  out  NREG  per-register load strobe; at most one bit high.
REQ-011 done  out  NREQ  one-cycle completion pulse to the granted requester.
REQ-012 err  out  1  high in the same cycle as done when the transfer was rejected.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 FSM states IDLE, DRIVE, LOAD, DONE; encoding is fixed in the package.
REQ-015 IDLE: when any req bit is high, select a winner per REQ-022, latch its src and dst, then go to DRIVE; otherwise stay in IDLE.
REQ-016 DRIVE: oe[src]=1, load=0; gives the bus one cycle to settle; next state is LOAD.
REQ-017 LOAD: oe[src]=1 and load[dst]=1 for exactly one cycle; the destination captures the bus on the next posedge; next state is DONE.
REQ-018 DONE: oe=0, load=0, done[winner]=1 for one cycle; next state is IDLE.
REQ-019 Latency: req sampled high at edge k; DRIVE in cycle k+1; LOAD in k+2; done in k+3; a new grant is possible in k+4.
REQ-020 Rejection: if src==dst, src>=NREG or dst>=NREG, go straight from IDLE to DONE with err=1; oe and load stay all-zero.
REQ-021 Deasserting req after the grant does not abort; the transfer completes and done still pulses.
REQ-022 Arbitration is evaluated only in IDLE; with BUSCTRL_RR_EN, see REQ-026 and REQ-027.
REQ-023 oe and load are registered outputs, so they are glitch-free; oe is never high for two different registers in the same cycle, including across transfer boundaries.

Reset
REQ-024 While reset is low: state=IDLE, oe=0, load=0, done=0, err=0, busy=0, latched src/dst=0 and round-robin pointer=0, taking effect immediately without waiting for clk.
REQ-025 If reset is asserted mid-transfer, the transfer is abandoned with no done pulse; the bus is released at once; after release the FSM starts in IDLE and re-arbitrates.

Configuration
REQ-026 Macro BUSCTRL_RR_EN defined: round-robin arbitration; the search starts at the requester after the last winner; the pointer advances only on a grant.
REQ-027 Macro BUSCTRL_RR_EN undefined: fixed priority, lowest requester index wins; no pointer register is built.

Structure
REQ-028 Package bus_ctrl_pkg holds the state enum typedef, the NREG/NREQ defaults and the index-width helper.
REQ-029 Arbitration is in sub-module rr_arbiter (NREQ request vector in, one-hot grant out, pointer inside, priority mode under the macro); the FSM and output decode stay in bus_xfer_ctrl.

Verification
REQ-030 Bench instantiates NREG regN (N=8) registers on one shared bus, driven by this block's oe and load.
REQ-031 Single transfer: reg0=0xA5, req[0] with src=0, dst=2 -> oe[0] high for 2 cycles, load[2] high for 1 cycle, reg2=0xA5, done[0] at k+3, err=0.
REQ-032 Contention with RR on: req[0] and req[1] held high continuously -> grants alternate 0,1,0,1; without the macro -> requester 0 always wins.
REQ-033 Invalid request: src=dst=1 -> done with err=1 at k+1; oe and load never asserted; busy high for 1 cycle only.
REQ-034 Reset during LOAD -> oe and load drop to 0 asynchronously before the next edge; no done pulse; the next request completes normally.
REQ-035 Bus-exclusivity assertion across 1000 random requests: $onehot0(oe) and $onehot0(load) hold every cycle; the bus never shows X while load is high.
